// File: rtl/pw_req_arb.sv
// pw_req_arb
// Request arbiter and response router sitting directly upstream of the page
// walk unit (PWU). NUM_REQ requesters compete round-robin for a single
// registered VA slot that feeds the PWU. The requester ID of every accepted
// request is queued in an in-order ID FIFO, so results coming back from the
// PWU (in issue order) are steered to the requester that issued them. At most
// MAX_OUT walks may be in flight between grant and PA return.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   reset_i      synchronous active-high reset
//   req_va_i     NUM_REQ x 32 packed per-requester VAs (requester i at [32*i +: 32])
//   req_vld_i    per-requester request valid
//   req_rdy_o    per-requester ready, one-hot for the round-robin winner or zero
//   rsp_pa_o     PA pass-through from the PWU, shared by all requesters
//   rsp_fault_o  fault pass-through from the PWU, shared
//   rsp_vld_o    per-requester response valid, one-hot on the FIFO head or zero
//   rsp_rdy_i    per-requester response ready
//   va_o         VA to the PWU
//   va_vld_o     VA valid to the PWU
//   va_rdy_i     PWU ready for a VA
//   pa_i         PA from the PWU
//   pa_vld_i     PA valid from the PWU
//   pa_fault_i   fault flag from the PWU
//   pa_rdy_o     ready back to the PWU
//   err_o        sticky protocol error: a PA arrived with nothing outstanding
//
// Handshake semantics (all interfaces): a transfer happens in a cycle where
// both valid and ready are high at the rising edge. Once raised, va_vld_o and
// va_o hold stable until the transfer. req_rdy_o and pa_rdy_o may depend
// combinationally on the corresponding valid inputs.

module pw_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ*32-1:0]   req_va_i,
  input  logic [NUM_REQ-1:0]      req_vld_i,
  output logic [NUM_REQ-1:0]      req_rdy_o,
  output logic [31:0]             rsp_pa_o,
  output logic                    rsp_fault_o,
  output logic [NUM_REQ-1:0]      rsp_vld_o,
  input  logic [NUM_REQ-1:0]      rsp_rdy_i,
  output logic [31:0]             va_o,
  output logic                    va_vld_o,
  input  logic                    va_rdy_i,
  input  logic [31:0]             pa_i,
  input  logic                    pa_vld_i,
  input  logic                    pa_fault_i,
  output logic                    pa_rdy_o,
  output logic                    err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int PW  = $clog2(MAX_OUT);

  localparam logic [CW-1:0]      CNT_MAX  = CW'(MAX_OUT);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]      PTR_ONE  = PW'(1);
  localparam logic [IDW-1:0]     ID_LAST  = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0]     ID_ONE   = IDW'(1);
  localparam logic [IDW:0]       REQ_N    = (IDW + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  // Unpacked view of the per-requester VAs.
  logic [31:0] va_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_va_unpack
    assign va_arr[g] = req_va_i[32*g +: 32];
  end

  // State
  logic [31:0]    slot_va_q;
  logic           slot_vld_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [IDW-1:0] fifo_q [MAX_OUT];
  logic           err_q;

  // Round-robin winner search, starting at rr_ptr_q.
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx_w;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_w = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
      if (idx_w >= REQ_N) idx_w = idx_w - REQ_N;
      if (!found && req_vld_i[idx_w[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx_w[IDW-1:0];
      end
    end
  end

  // The slot can take a new VA when it is empty or is being drained right
  // now. Capacity uses the registered count only, so a PA pop in this cycle
  // does not open a grant until the following cycle.
  logic slot_free;
  logic grant;
  logic empty;
  logic [IDW-1:0] head;
  logic pop;

  assign slot_free = !slot_vld_q || va_rdy_i;
  assign grant     = !reset_i && slot_free && (cnt_q < CNT_MAX) && found;
  assign req_rdy_o = grant ? (ONE_HOT0 << win) : '0;

  assign va_o     = slot_va_q;
  assign va_vld_o = slot_vld_q;

  // Response routing: straight pass-through of the PWU result, with valid
  // steered to the requester at the FIFO head.
  assign empty       = (cnt_q == '0);
  assign head        = fifo_q[rd_ptr_q];
  assign rsp_pa_o    = pa_i;
  assign rsp_fault_o = pa_fault_i;
  assign rsp_vld_o   = (!reset_i && pa_vld_i && !empty) ? (ONE_HOT0 << head) : '0;
  assign pa_rdy_o    = !reset_i && !empty && rsp_rdy_i[head];
  assign pop         = pa_vld_i && pa_rdy_o;
  assign err_o       = err_q;

  // Output slot and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_va_q  <= '0;
      slot_vld_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else if (grant) begin
      slot_va_q  <= va_arr[win];
      slot_vld_q <= 1'b1;
      rr_ptr_q   <= (win == ID_LAST) ? '0 : win + ID_ONE;
    end else if (slot_vld_q && va_rdy_i) begin
      slot_vld_q <= 1'b0;
    end
  end

  // ID FIFO and outstanding count. The count doubles as the FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= win;
        wr_ptr_q         <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (grant && !pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (!grant && pop) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Sticky protocol error: a PA with no walk outstanding is never accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i)                 err_q <= 1'b0;
    else if (pa_vld_i && empty)  err_q <= 1'b1;
  end

endmodule

// File: tb/tb_pw_req_arb.sv
// Bench for pw_req_arb. Inputs change on the falling edge; outputs are
// compared 1 ns later against a transaction-level reference model (queue of
// outstanding requester IDs, round-robin pointer as an integer, one VA slot),
// and the model advances on the rising edge.

module tb_pw_req_arb;

  localparam int N       = 4;
  localparam int MAX_OUT = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  // ---------------- DUT I/O ----------------
  logic [N*32-1:0] req_va_i;
  logic [N-1:0]    req_vld_i;
  logic [N-1:0]    req_rdy_o;
  logic [31:0]     rsp_pa_o;
  logic            rsp_fault_o;
  logic [N-1:0]    rsp_vld_o;
  logic [N-1:0]    rsp_rdy_i;
  logic [31:0]     va_o;
  logic            va_vld_o;
  logic            va_rdy_i;
  logic [31:0]     pa_i;
  logic            pa_vld_i;
  logic            pa_fault_i;
  logic            pa_rdy_o;
  logic            err_o;

  logic [31:0] va_arr [N];
  always_comb begin
    req_va_i = '0;
    for (int i = 0; i < N; i++) req_va_i[32*i +: 32] = va_arr[i];
  end

  pw_req_arb #(.NUM_REQ(N), .MAX_OUT(MAX_OUT)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_va_i    (req_va_i),
    .req_vld_i   (req_vld_i),
    .req_rdy_o   (req_rdy_o),
    .rsp_pa_o    (rsp_pa_o),
    .rsp_fault_o (rsp_fault_o),
    .rsp_vld_o   (rsp_vld_o),
    .rsp_rdy_i   (rsp_rdy_i),
    .va_o        (va_o),
    .va_vld_o    (va_vld_o),
    .va_rdy_i    (va_rdy_i),
    .pa_i        (pa_i),
    .pa_vld_i    (pa_vld_i),
    .pa_fault_i  (pa_fault_i),
    .pa_rdy_o    (pa_rdy_o),
    .err_o       (err_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];   // VAs in expected issue order to the PWU
  int          id_q  [$];   // requester IDs of walks outstanding, oldest first
  int          m_ptr;       // round-robin start
  logic        m_vld;       // slot holds a VA
  logic [31:0] m_va;
  logic        m_va_def;    // va_o value is defined (after reset or while valid)
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    id_q.delete();
    m_ptr    = 0;
    m_vld    = 1'b0;
    m_va     = '0;
    m_va_def = 1'b1;
    m_err    = 1'b0;
  endtask

  // One clock: compare outputs for the inputs currently driven, then step.
  task automatic cycle();
    int          sz;
    int          w;
    int          head;
    logic        grant;
    logic        free;
    logic        exp_pa_rdy;
    logic [N-1:0] exp_req_rdy;
    logic [N-1:0] exp_rsp_vld;
    #1;
    sz    = id_q.size();
    free  = !m_vld || va_rdy_i;
    grant = 1'b0;
    w     = 0;
    if (!reset_i && free && sz < MAX_OUT) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!grant && req_vld_i[k]) begin
          grant = 1'b1;
          w     = k;
        end
      end
    end
    exp_req_rdy = grant ? N'(1 << w) : '0;
    head        = (sz > 0) ? id_q[0] : 0;
    exp_rsp_vld = (!reset_i && pa_vld_i && sz > 0) ? N'(1 << head) : '0;
    exp_pa_rdy  = !reset_i && sz > 0 && rsp_rdy_i[head];

    check("req_rdy_o",   32'(req_rdy_o),   32'(exp_req_rdy));
    check("va_vld_o",    32'(va_vld_o),    32'(m_vld));
    if (m_va_def) check("va_o", va_o, m_va);
    check("rsp_vld_o",   32'(rsp_vld_o),   32'(exp_rsp_vld));
    check("pa_rdy_o",    32'(pa_rdy_o),    32'(exp_pa_rdy));
    check("rsp_pa_o",    rsp_pa_o,         pa_i);
    check("rsp_fault_o", 32'(rsp_fault_o), 32'(pa_fault_i));
    check("err_o",       32'(err_o),       32'(m_err));
    if (va_vld_o && va_rdy_i && exp_q.size() > 0)
      check("va_issue_order", va_o, exp_q.pop_front());

    @(posedge clk_i);
    if (reset_i) begin
      model_reset();
    end else begin
      if (pa_vld_i && sz == 0) m_err = 1'b1;
      if (pa_vld_i && exp_pa_rdy) void'(id_q.pop_front());
      if (grant) begin
        id_q.push_back(w);
        exp_q.push_back(va_arr[w]);
        m_vld    = 1'b1;
        m_va     = va_arr[w];
        m_va_def = 1'b1;
        m_ptr    = (w + 1) % N;
      end else if (m_vld && va_rdy_i) begin
        m_vld    = 1'b0;
        m_va_def = 1'b0;
      end
    end
    @(negedge clk_i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    req_vld_i  = '0;
    rsp_rdy_i  = '1;
    va_rdy_i   = 1'b1;
    pa_vld_i   = 1'b0;
    pa_fault_i = 1'b0;
    pa_i       = '0;
  endtask

  task automatic rand_vas();
    for (int i = 0; i < N; i++) va_arr[i] = $urandom;
  endtask

  // Return every outstanding walk and empty the slot; bounded.
  task automatic drain();
    set_idle();
    for (int c = 0; c < 20; c++) begin
      if (id_q.size() == 0 && !m_vld) break;
      pa_vld_i = (id_q.size() > 0);
      pa_i     = $urandom;
      cycle();
    end
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_i = 1'b1;
    set_idle();
    for (int i = 0; i < N; i++) va_arr[i] = '0;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    cycle();                        // reset state, still in reset
    reset_i = 1'b0;
    cycle();
    cycle();

    // Single request from requester 2, then its PA.
    va_arr[2] = 32'h0000_1234;
    req_vld_i = 4'b0100;
    cycle();
    req_vld_i = '0;
    cycle();                        // va_vld_o with 0x1234
    pa_i = 32'hABCD_0234;
    pa_vld_i = 1'b1;
    cycle();                        // rsp_vld_o=0100, pa_rdy_o=1
    drain();

    // Round-robin with all requesters valid and prompt PA return.
    req_vld_i = '1;
    for (int c = 0; c < 12; c++) begin
      rand_vas();
      pa_vld_i = (id_q.size() > 0);
      pa_i     = $urandom;
      cycle();
    end
    drain();

    // Fill with ids 1,3,0,2, stall the 5th, then return PAs (2nd faults).
    begin
      int ids [4] = '{1, 3, 0, 2};
      for (int k = 0; k < 4; k++) begin
        rand_vas();
        req_vld_i = N'(1 << ids[k]);
        cycle();
      end
      req_vld_i = '1;
      cycle();
      cycle();
      for (int k = 0; k < 4; k++) begin
        pa_vld_i   = 1'b1;
        pa_fault_i = (k == 1);
        pa_i       = $urandom;
        cycle();
      end
      pa_fault_i = 1'b0;
    end
    drain();

    // VA back-pressure for 3 cycles, then release.
    req_vld_i = '1;
    rand_vas();
    cycle();
    va_rdy_i = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    va_rdy_i = 1'b1;
    cycle();
    cycle();
    drain();

    // Response back-pressure with a PA pending, and grant+pop together.
    req_vld_i = 4'b0011;
    cycle();
    cycle();
    req_vld_i = '0;
    pa_vld_i  = 1'b1;
    rsp_rdy_i = '0;
    cycle();
    cycle();
    rsp_rdy_i = '1;
    req_vld_i = 4'b1000;
    cycle();
    drain();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      rand_vas();
      req_vld_i  = N'($urandom_range(0, (1 << N) - 1));
      va_rdy_i   = ($urandom_range(0, 3) != 0);
      rsp_rdy_i  = N'($urandom_range(0, (1 << N) - 1)) | N'($urandom_range(0, (1 << N) - 1));
      pa_vld_i   = (id_q.size() > 0) && ($urandom_range(0, 1) == 1);
      pa_fault_i = ($urandom_range(0, 7) == 0);
      pa_i       = $urandom;
      cycle();
    end
    drain();

    // Protocol error: PA with nothing outstanding, sticky until reset.
    pa_vld_i = 1'b1;
    pa_i     = 32'hDEAD_0000;
    cycle();
    pa_vld_i = 1'b0;
    cycle();
    cycle();

    // Three walks outstanding, then reset mid-operation.
    req_vld_i = '1;
    for (int c = 0; c < 3; c++) begin
      rand_vas();
      cycle();
    end
    req_vld_i = '0;
    va_rdy_i  = 1'b0;
    cycle();
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    va_rdy_i = 1'b1;
    cycle();                        // all outputs at reset values
    pa_vld_i = 1'b1;                // stale PA after reset -> protocol error
    cycle();
    pa_vld_i = 1'b0;
    cycle();
    // Full capacity is available again after reset.
    req_vld_i = '1;
    for (int c = 0; c < 6; c++) begin
      rand_vas();
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
